// File: rtl/ps2_kbd_decoder.sv
// PS/2 Set-2 scan-code decoder: parses E0/F0/E1 sequences into key events,
// tracks Shift/Ctrl state and queues events in a show-ahead FIFO.
module ps2_kbd_decoder #(
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [7:0]         rx_data,
  input  logic               rd_en,
  input  logic               ovf_clr,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               shift,
  output logic               ctrl
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam int unsigned TMO_W  = 22;
  localparam int unsigned SKIP_W = 3;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(7);

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_12 = 8'h12;
  localparam logic [7:0] K_LSHIFT = 8'h12;
  localparam logic [7:0] K_RSHIFT = 8'h59;
  localparam logic [7:0] K_CTRL   = 8'h14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kev_t;

  state_e              state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                push_c;
  kev_t                pev_c;
  logic                is_filler_c;

  logic                lshift_q, lshift_d;
  logic                rshift_q, rshift_d;
  logic                lctrl_q, lctrl_d;
  logic                rctrl_q, rctrl_d;

  kev_t                mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                empty_c, full_c;
  logic                push_ok_c, pop_ok_c, ovf_set_c;
  kev_t                head_c;

  // Keyboard status/ack bytes that never form part of a key sequence.
  assign is_filler_c = (rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});

  // Parser state, skip counter and mid-sequence timeout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and event generation; a byte always beats the timeout.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    push_c  = 1'b0;
    pev_c   = '0;
    if (rx_done_tick) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == B_E0) begin
            state_d = ST_EXT;
          end else if (rx_data == B_F0) begin
            state_d = ST_BRK;
          end else if (rx_data == B_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_INIT;
          end else if (!is_filler_c) begin
            push_c = 1'b1;
            pev_c  = '{ext: 1'b0, brk: 1'b0, code: rx_data};
          end
        end
        ST_EXT: begin
          if (rx_data == B_F0) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == B_E0) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            // E0 12 is the Print Screen fake shift
            if (rx_data != B_12) begin
              push_c = 1'b1;
              pev_c  = '{ext: 1'b1, brk: 1'b0, code: rx_data};
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          push_c  = 1'b1;
          pev_c   = '{ext: 1'b0, brk: 1'b1, code: rx_data};
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (rx_data != B_12) begin
            push_c = 1'b1;
            pev_c  = '{ext: 1'b1, brk: 1'b1, code: rx_data};
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Modifier tracking follows every decoded event, even ones the FIFO drops.
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    if (push_c) begin
      if (!pev_c.ext && pev_c.code == K_LSHIFT) lshift_d = ~pev_c.brk;
      if (!pev_c.ext && pev_c.code == K_RSHIFT) rshift_d = ~pev_c.brk;
      if (!pev_c.ext && pev_c.code == K_CTRL)   lctrl_d  = ~pev_c.brk;
      if (pev_c.ext  && pev_c.code == K_CTRL)   rctrl_d  = ~pev_c.brk;
    end
  end

  // Modifier registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
    end
  end

  assign empty_c   = (level_q == '0);
  assign full_c    = (level_q == LVL_FULL);
  assign pop_ok_c  = rd_en & ~empty_c;
  assign push_ok_c = push_c & (~full_c | rd_en);
  assign ovf_set_c = push_c & full_c & ~rd_en;

  // FIFO pointer, level and sticky overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push_ok_c && !pop_ok_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      level_d = level_q - LVL_W'(1);
    end
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_c) begin
      mem_q[wr_ptr_q] <= pev_c;
    end
  end

  assign head_c   = mem_q[rd_ptr_q];
  assign ev_code  = empty_c ? 8'h00 : head_c.code;
  assign ev_ext   = empty_c ? 1'b0  : head_c.ext;
  assign ev_break = empty_c ? 1'b0  : head_c.brk;
  assign empty    = empty_c;
  assign full     = full_c;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign shift    = lshift_q | rshift_q;
  assign ctrl     = lctrl_q | rctrl_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: directed table, hand sequences,
// and random byte streams against a prefix-flag reference model.
module tb_ps2_kbd_decoder;

  localparam int unsigned TMO = 16;
  localparam int unsigned AW  = 3;
  localparam int          DEP = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           rx_done_tick;
  logic [7:0]     rx_data;
  logic           rd_en;
  logic           ovf_clr;
  logic [7:0]     ev_code;
  logic           ev_ext;
  logic           ev_break;
  logic           empty;
  logic           full;
  logic [AW:0]    level;
  logic           overflow;
  logic           shift;
  logic           ctrl;

  always #5 clk = ~clk;

  ps2_kbd_decoder #(.TIMEOUT_CYC(TMO), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .empty(empty), .full(full), .level(level),
    .overflow(overflow), .shift(shift), .ctrl(ctrl)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: event queue, prefix flags, modifier set.
  logic [9:0] mq[$];
  bit m_e0, m_f0, m_lsh, m_rsh, m_lct, m_rct, m_ovf, m_ovs;
  int m_skip, m_gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_ovf = 0;
  endtask

  task automatic model_emit(input bit ext, input bit brk, input logic [7:0] code);
    if (!ext && code == 8'h12) m_lsh = !brk;
    if (!ext && code == 8'h59) m_rsh = !brk;
    if (!ext && code == 8'h14) m_lct = !brk;
    if (ext  && code == 8'h14) m_rct = !brk;
    if (mq.size() < DEP) mq.push_back({ext, brk, code});
    else m_ovs = 1;
  endtask

  task automatic model_step(input bit tk, input logic [7:0] b, input bit rd, input bit clr);
    m_ovs = 0;
    if (rd && mq.size() > 0) mq.delete(0);
    if (tk) begin
      m_gap = 0;
      if (m_skip > 0) m_skip--;
      else if (m_f0) begin
        if (!(m_e0 && b == 8'h12)) model_emit(m_e0, 1'b1, b);
        m_e0 = 0; m_f0 = 0;
      end
      else if (b == 8'hF0) m_f0 = 1;
      else if (m_e0) begin
        if (b != 8'hE0) begin
          if (b != 8'h12) model_emit(1'b1, 1'b0, b);
          m_e0 = 0;
        end
      end
      else if (b == 8'hE0) m_e0 = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) model_emit(1'b0, 1'b0, b);
    end else if (m_e0 || m_f0 || m_skip > 0) begin
      m_gap++;
      if (m_gap >= int'(TMO)) begin
        m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
      end
    end
    if (m_ovs) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  function automatic logic [9:0] head_act();
    return {ev_ext, ev_break, ev_code};
  endfunction

  task automatic compare_all();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEP));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("shift", 32'(shift), 32'(m_lsh | m_rsh));
    chk("ctrl", 32'(ctrl), 32'(m_lct | m_rct));
    chk("head", 32'(head_act()), 32'(h));
  endtask

  // One clock: drive at negedge, model it, sample at the next negedge.
  task automatic cycle(input bit tk, input logic [7:0] b, input bit rd, input bit clr);
    rx_done_tick = tk; rx_data = b; rd_en = rd; ovf_clr = clr;
    model_step(tk, b, rd, clr);
    @(negedge clk);
    rx_done_tick = 0; rd_en = 0; ovf_clr = 0;
    compare_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 chk("async_rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    compare_all();
  endtask

  typedef struct {
    logic [7:0] b;
    bit         push;
    logic [9:0] ev;
    bit         sh;
    bit         ct;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [7:0] b, input bit p, input logic [9:0] ev, input bit sh, input bit ct);
    vec_t v;
    v.b = b; v.push = p; v.ev = ev; v.sh = sh; v.ct = ct;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    reset = 1'b1; rx_done_tick = 0; rx_data = 8'h00; rd_en = 0; ovf_clr = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    compare_all();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);

    // make then break of 1C
    cycle(1, 8'h1C, 0, 0);
    chk("t1_lvl1", 32'(level), 32'd1);
    chk("t1_head1", 32'(head_act()), 32'h01C);
    cycle(1, 8'hF0, 0, 0);
    cycle(1, 8'h1C, 0, 0);
    chk("t1_lvl2", 32'(level), 32'd2);
    cycle(0, 8'h00, 1, 0);
    chk("t1_head2", 32'(head_act()), 32'h11C);
    cycle(0, 8'h00, 1, 0);
    chk("t1_empty", 32'(empty), 32'd1);

    // directed vector table: byte, pushed?, event {ext,brk,code}, shift, ctrl
    add(8'h12, 1, 10'h012, 1, 0);
    add(8'h14, 1, 10'h014, 1, 1);
    add(8'hE0, 0, 10'h000, 1, 1);
    add(8'h14, 1, 10'h214, 1, 1);
    add(8'hF0, 0, 10'h000, 1, 1);
    add(8'h12, 1, 10'h112, 0, 1);
    add(8'hE0, 0, 10'h000, 0, 1);
    add(8'hF0, 0, 10'h000, 0, 1);
    add(8'h14, 1, 10'h314, 0, 1);
    add(8'hF0, 0, 10'h000, 0, 1);
    add(8'h14, 1, 10'h114, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'h12, 0, 10'h000, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'hF0, 0, 10'h000, 0, 0);
    add(8'h12, 0, 10'h000, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'h75, 1, 10'h275, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'hF0, 0, 10'h000, 0, 0);
    add(8'h75, 1, 10'h375, 0, 0);
    add(8'hAA, 0, 10'h000, 0, 0);
    add(8'hFA, 0, 10'h000, 0, 0);
    add(8'hE1, 0, 10'h000, 0, 0);
    add(8'h14, 0, 10'h000, 0, 0);
    add(8'h77, 0, 10'h000, 0, 0);
    add(8'hE1, 0, 10'h000, 0, 0);
    add(8'hF0, 0, 10'h000, 0, 0);
    add(8'h14, 0, 10'h000, 0, 0);
    add(8'hF0, 0, 10'h000, 0, 0);
    add(8'h77, 0, 10'h000, 0, 0);
    add(8'h1C, 1, 10'h01C, 0, 0);
    add(8'h59, 1, 10'h059, 1, 0);
    add(8'hF0, 0, 10'h000, 1, 0);
    add(8'h59, 1, 10'h159, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'hE0, 0, 10'h000, 0, 0);
    add(8'h75, 1, 10'h275, 0, 0);
    foreach (vt[i]) begin
      cycle(1, vt[i].b, 0, 0);
      chk("vec_lvl", 32'(level), 32'(vt[i].push));
      chk("vec_shift", 32'(shift), 32'(vt[i].sh));
      chk("vec_ctrl", 32'(ctrl), 32'(vt[i].ct));
      if (vt[i].push) begin
        chk("vec_head", 32'(head_act()), 32'(vt[i].ev));
        cycle(0, 8'h00, 1, 0);
      end
    end

    // overflow: 9 makes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) cycle(1, 8'(8'h15 + i), 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(head_act()), 32'h015);
    cycle(1, 8'h2A, 1, 0);
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_head", 32'(head_act()), 32'h016);
    cycle(1, 8'h2B, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cycle(0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    repeat (8) cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h33, 1, 0);
    chk("emptypp_level", 32'(level), 32'd1);
    cycle(0, 8'h00, 1, 0);

    // timeout boundary: a byte on the last counted cycle still belongs to E0
    cycle(1, 8'hE0, 0, 0);
    repeat (TMO - 1) cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h75, 0, 0);
    chk("tmo_edge_head", 32'(head_act()), 32'h275);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hE0, 0, 0);
    repeat (TMO) cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h75, 0, 0);
    chk("tmo_head", 32'(head_act()), 32'h075);
    cycle(0, 8'h00, 1, 0);

    // reset after F0 discards the prefix and empties the FIFO
    cycle(1, 8'h1C, 0, 0);
    cycle(1, 8'hF0, 0, 0);
    do_reset();
    chk("rst_mid_empty", 32'(empty), 32'd1);
    cycle(1, 8'h1C, 0, 0);
    chk("rst_mid_head", 32'(head_act()), 32'h01C);
    chk("rst_mid_level", 32'(level), 32'd1);

    // random byte streams
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 12))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hE1;
        3: rb = 8'h12;
        4: rb = 8'h59;
        5: rb = 8'h14;
        6: rb = 8'h1C;
        7: rb = 8'h75;
        8: rb = 8'hAA;
        9: rb = 8'hFA;
        10: rb = 8'hF0;
        default: rb = 8'($urandom);
      endcase
      cycle(bit'($urandom_range(0, 1)), rb, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
    end
    // a long idle gap mid-sequence exercises the timeout under random state
    cycle(1, 8'hE0, 0, 0);
    repeat (TMO + 3) cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h14, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
